// File: rtl/kangaroo_rom_pkg.sv
// Shared constants and FSM encoding for the 2732 EPROM fetch path.
package kangaroo_rom_pkg;

  localparam int ROM_DATA_W = 8;
  localparam int ROM_ADDR_W = 12;
  localparam logic [ROM_DATA_W-1:0] ROM_ERASED = 8'hFF;

  typedef enum logic [2:0] {
    IDLE,
    SETUP,
    ACCESS,
    CAPTURE,
    RECOVER,
    PREFETCH
  } fetch_state_t;

endpackage

// File: rtl/rom_bank_select.sv
// Bank index + enable to active-low one-hot chip-enable vector.
module rom_bank_select
  import kangaroo_rom_pkg::*;
#(
  parameter  int NUM_ROMS = 4,
  localparam int BANK_W   = (NUM_ROMS > 1) ? $clog2(NUM_ROMS) : 1
) (
  input  logic [BANK_W-1:0]   bank,
  input  logic                en,
  output logic [NUM_ROMS-1:0] e_n
);

  for (genvar i = 0; i < NUM_ROMS; i++) begin : g_chip
    assign e_n[i] = ~(en && (bank == BANK_W'(i)));
  end

endmodule

// File: rtl/rom_fetch_sequencer.sv
// Byte-read sequencer for a bank of 2732 EPROMs: decode, paced E/G timing, capture of ROM_Q.
// Define ROM_PREFETCH_EN to add a one-entry sequential prefetch buffer.
module rom_fetch_sequencer
  import kangaroo_rom_pkg::*;
#(
  parameter  int NUM_ROMS      = 4,
  parameter  int ACCESS_CYCLES = 3,
  parameter  int TURN_CYCLES   = 1,
  localparam int ADDR_W        = ROM_ADDR_W + $clog2(NUM_ROMS)
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  REQ,
  input  logic [ADDR_W-1:0]     ADDR,
  output logic                  ACK,
  output logic                  BUSY,
  output logic [ROM_DATA_W-1:0] DOUT,
  output logic                  DVALID,
  output logic [ROM_ADDR_W-1:0] ROM_A,
  output logic [NUM_ROMS-1:0]   ROM_E_N,
  output logic                  ROM_G_N,
  input  logic [ROM_DATA_W-1:0] ROM_Q
);

  localparam int BANK_W  = (NUM_ROMS > 1) ? $clog2(NUM_ROMS) : 1;
  localparam int CNT_MAX = (ACCESS_CYCLES > TURN_CYCLES) ? ACCESS_CYCLES : TURN_CYCLES;
  localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
  localparam logic [CNT_W-1:0] ACC_LD  = CNT_W'(ACCESS_CYCLES - 1);
  localparam logic [CNT_W-1:0] TURN_LD = CNT_W'((TURN_CYCLES > 0) ? TURN_CYCLES - 1 : 0);

  fetch_state_t            state, state_nxt;
  logic [ADDR_W-1:0]       a_q;
  logic [CNT_W-1:0]        cnt;
  logic [ROM_DATA_W-1:0]   dout_q;
  logic [BANK_W-1:0]       bank;
  logic                    sel_en;

`ifdef ROM_PREFETCH_EN
  logic                    pf_run;
  logic                    pf_valid;
  logic [ROM_DATA_W-1:0]   pf_data;
  logic [ADDR_W-1:0]       pf_addr;
  logic                    hit;
  logic                    post;
  logic                    pf_start;

  assign hit  = pf_valid && (ADDR == pf_addr);
  // Last cycle of an access sequence (end of RECOVER, or CAPTURE when there is no turnaround).
  assign post = (state == CAPTURE && TURN_CYCLES == 0) || (state == RECOVER && cnt == '0);
  assign pf_start = (state == PREFETCH) || (post && !pf_run && !REQ);
`endif

  assign ACK   = REQ && (state == IDLE) && !RST;
  assign BUSY  = (state != IDLE);
  assign DOUT  = dout_q;
  assign ROM_A = a_q[ROM_ADDR_W-1:0];

  // State register
  always_ff @(posedge CLK) begin
    if (RST) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE: begin
`ifdef ROM_PREFETCH_EN
        if (REQ) state_nxt = hit ? PREFETCH : SETUP;
`else
        if (REQ) state_nxt = SETUP;
`endif
      end
      SETUP:   state_nxt = ACCESS;
      ACCESS:  if (cnt == '0) state_nxt = CAPTURE;
      CAPTURE: state_nxt = (TURN_CYCLES == 0) ? IDLE : RECOVER;
      RECOVER: if (cnt == '0) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
`ifdef ROM_PREFETCH_EN
    if (pf_start) state_nxt = SETUP;
`endif
  end

  // Datapath: address latch, timing counter, capture registers
  always_ff @(posedge CLK) begin
    if (RST) begin
      a_q    <= '0;
      cnt    <= '0;
      dout_q <= ROM_ERASED;
`ifdef ROM_PREFETCH_EN
      pf_run   <= 1'b0;
      pf_valid <= 1'b0;
      pf_data  <= ROM_ERASED;
      pf_addr  <= '0;
`endif
    end else begin
      if (ACK) a_q <= ADDR;

      if (state == SETUP)
        cnt <= ACC_LD;
      else if (state == CAPTURE)
        cnt <= TURN_LD;
      else if ((state == ACCESS || state == RECOVER) && cnt != '0)
        cnt <= cnt - CNT_W'(1);

      if (state == ACCESS && cnt == '0) begin
`ifdef ROM_PREFETCH_EN
        if (pf_run) begin
          pf_data  <= ROM_Q;
          pf_addr  <= a_q;
          pf_valid <= 1'b1;
        end else begin
          dout_q <= ROM_Q;
        end
`else
        dout_q <= ROM_Q;
`endif
      end

`ifdef ROM_PREFETCH_EN
      if (ACK && hit) dout_q <= pf_data;
      if (post) pf_run <= 1'b0;
      // Address wraps naturally at 2^ADDR_W.
      if (pf_start) begin
        a_q    <= a_q + ADDR_W'(1);
        pf_run <= 1'b1;
      end
`endif
    end
  end

  // Output decode
  always_comb begin
    sel_en  = 1'b0;
    ROM_G_N = 1'b1;
    DVALID  = 1'b0;
    unique case (state)
      SETUP:  sel_en = 1'b1;
      ACCESS: begin
        sel_en  = 1'b1;
        ROM_G_N = 1'b0;
      end
`ifdef ROM_PREFETCH_EN
      CAPTURE:  DVALID = !pf_run;
`else
      CAPTURE:  DVALID = 1'b1;
`endif
      PREFETCH: DVALID = 1'b1;
      default: ;
    endcase
  end

  if (NUM_ROMS > 1) begin : g_bank
    assign bank = a_q[ADDR_W-1:ROM_ADDR_W];
  end else begin : g_nobank
    assign bank = '0;
  end

  rom_bank_select #(.NUM_ROMS(NUM_ROMS)) u_sel (
    .bank (bank),
    .en   (sel_en),
    .e_n  (ROM_E_N)
  );

endmodule

// File: tb/tb_rom_fetch_sequencer.sv
// Directed bench: four EPROM models on a shared bus, DOUT checked through a scoreboard.
module tb_rom_fetch_sequencer;

  logic        CLK = 1'b0;
  logic        RST;
  logic        REQ;
  logic [13:0] ADDR;
  logic        ACK, BUSY, DVALID, ROM_G_N;
  logic [7:0]  DOUT, ROM_Q;
  logic [11:0] ROM_A;
  logic [3:0]  ROM_E_N;

  int total = 0;
  int bad   = 0;
  logic [7:0] sb[$];

  always #5 CLK = ~CLK;

  rom_fetch_sequencer dut (
    .CLK(CLK), .RST(RST), .REQ(REQ), .ADDR(ADDR), .ACK(ACK), .BUSY(BUSY),
    .DOUT(DOUT), .DVALID(DVALID), .ROM_A(ROM_A), .ROM_E_N(ROM_E_N),
    .ROM_G_N(ROM_G_N), .ROM_Q(ROM_Q)
  );

  // Chip n holds memory[i] = i[7:0] ^ n; undriven bus reads as 8'hEE.
  always_comb begin
    ROM_Q = 8'hEE;
    for (int n = 0; n < 4; n++)
      if (!ROM_E_N[n] && !ROM_G_N) ROM_Q = ROM_A[7:0] ^ 8'(n);
  end

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h @%0t", nm, got, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic wait_ack(input string nm);
    int n;
    n = 0;
    @(negedge CLK);
    while (!ACK && n < 60) begin
      @(negedge CLK);
      n++;
    end
    chk(nm, ACK, 1'b1);
  endtask

  task automatic wait_idle(input string nm);
    int n;
    n = 0;
    @(negedge CLK);
    while (BUSY && n < 60) begin
      @(negedge CLK);
      n++;
    end
    chk(nm, BUSY, 1'b0);
  endtask

  // Monitor: bus invariants every cycle, DOUT popped against the scoreboard on DVALID.
  always @(negedge CLK) begin
    if (!RST) begin
      chk("one_select", ($countones(~ROM_E_N) <= 1), 1'b1);
      chk("g_without_e", (!ROM_G_N && (&ROM_E_N)), 1'b0);
      if (DVALID) begin
        if (sb.size() == 0) chk("unexpected_dvalid", DVALID, 1'b0);
        else chk("dout", DOUT, sb.pop_front());
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    int gap;
    RST = 1'b1; REQ = 1'b0; ADDR = '0;
    repeat (2) @(posedge CLK);
    #1 RST = 1'b0;
    @(negedge CLK);
    chk("rst_e_n", ROM_E_N, 4'hF);
    chk("rst_g_n", ROM_G_N, 1'b1);
    chk("rst_dout", DOUT, 8'hFF);
    chk("rst_dvalid", DVALID, 1'b0);
    chk("rst_busy", BUSY, 1'b0);
    chk("rst_ack", ACK, 1'b0);

    // Single read with cycle-accurate select/latency checks
    step(); REQ = 1'b1; ADDR = 14'h1ABC;
    wait_ack("ack_single");
    sb.push_back(8'hBD);
    for (int k = 1; k <= 6; k++) begin
      step();
      if (k == 1) REQ = 1'b0;
      @(negedge CLK);
      chk("single_dvalid", DVALID, (k == 5));
      chk("single_e_n", ROM_E_N, (k <= 4) ? 4'b1101 : 4'hF);
      chk("single_g_n", ROM_G_N, (k >= 2 && k <= 4) ? 1'b0 : 1'b1);
      if (k == 1) chk("single_rom_a", ROM_A, 12'hABC);
    end
    wait_idle("idle_single");

    // Back-to-back across banks with REQ held
    step(); REQ = 1'b1; ADDR = 14'h0FFF;
    wait_ack("ack_b2b_0");
    sb.push_back(8'hFF);
    step(); ADDR = 14'h1000;
    gap = 0;
    do begin
      @(negedge CLK);
      gap++;
    end while (!ACK && gap < 40);
    chk("b2b_gap", gap, 7);
    sb.push_back(8'h01);
    step(); REQ = 1'b0;
    wait_idle("idle_b2b");

    // Request during ACCESS is ignored
    step(); REQ = 1'b1; ADDR = 14'h0123;
    wait_ack("ack_busy");
    sb.push_back(8'h23);
    step(); REQ = 1'b0;
    step(); REQ = 1'b1; ADDR = 14'h2000;
    for (int k = 2; k <= 4; k++) begin
      @(negedge CLK);
      chk("ack_while_busy", ACK, 1'b0);
      if (k < 4) step();
    end
    step(); REQ = 1'b0;
    wait_idle("idle_busy");

    // Reset during the second ACCESS cycle drops the read
    step(); REQ = 1'b1; ADDR = 14'h2222;
    wait_ack("ack_rst");
    step(); REQ = 1'b0;
    step();
    step(); RST = 1'b1;
    step(); RST = 1'b0;
    @(negedge CLK);
    chk("midrst_e_n", ROM_E_N, 4'hF);
    chk("midrst_g_n", ROM_G_N, 1'b1);
    chk("midrst_dvalid", DVALID, 1'b0);
    chk("midrst_busy", BUSY, 1'b0);
    chk("midrst_dout", DOUT, 8'hFF);
    repeat (4) @(negedge CLK);
    step(); REQ = 1'b1; ADDR = 14'h0003;
    wait_ack("ack_after_rst");
    sb.push_back(8'h03);
    step(); REQ = 1'b0;
    wait_idle("idle_after_rst");

`ifdef ROM_PREFETCH_EN
    // Wrap-around prefetch, hit, then a miss queued behind a running prefetch
    step(); REQ = 1'b1; ADDR = 14'h3FFF;
    wait_ack("ack_pf_seed");
    sb.push_back(8'hFC);
    step(); REQ = 1'b0;
    wait_idle("idle_pf_seed");
    step(); REQ = 1'b1; ADDR = 14'h0000;
    @(negedge CLK);
    chk("hit_ack", ACK, 1'b1);
    chk("hit_e_n_ack", ROM_E_N, 4'hF);
    sb.push_back(8'h00);
    step(); REQ = 1'b0;
    @(negedge CLK);
    chk("hit_dvalid", DVALID, 1'b1);
    chk("hit_e_n", ROM_E_N, 4'hF);
    step(); REQ = 1'b1; ADDR = 14'h0005;
    wait_ack("ack_pf_miss");
    sb.push_back(8'h05);
    for (int k = 1; k <= 6; k++) begin
      step();
      if (k == 1) REQ = 1'b0;
      @(negedge CLK);
      chk("miss_dvalid", DVALID, (k == 5));
    end
    wait_idle("idle_pf_miss");
`endif

    repeat (5) @(negedge CLK);
    chk("sb_empty", sb.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
